load_use_scoreboard: RTL and testbench

- Producer-side companion to the EX2 forwarding selection.
- Tracks destination registers of in-flight instructions from EX1 through MEM, with a per-entry countdown to when each result reaches a forwarding path.
- When an instruction in ID sources a register whose producer cannot yet forward, stalls IF/ID and injects a bubble into EX1.
- Also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/load_use_scoreboard_pkg.sv | 21 ++
 rtl/load_use_scoreboard_if.sv | 28 ++
 rtl/load_use_scoreboard_match.sv | 29 ++
 rtl/load_use_scoreboard.sv | 73 +++++++
 tb/tb_load_use_scoreboard.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_use_scoreboard_pkg.sv
// Shared hazard-tracking types and constants for the load-use scoreboard.
package load_use_scoreboard_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned CNT_BITS = 2;
  localparam int unsigned ALU_LAT  = 0;
  localparam int unsigned LOAD_LAT = 2;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                valid;
    logic [REG_W-1:0]    dest;
    logic [CNT_BITS-1:0] cnt;
  } slot_t;

  function automatic logic [CNT_BITS-1:0] cnt_dec(input logic [CNT_BITS-1:0] c);
    return (c == '0) ? '0 : c - CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// ID-stage request and stall/bubble response bundle between decode and the scoreboard.
interface load_use_scoreboard_if;
  import load_use_scoreboard_pkg::*;

  logic [REG_W-1:0] rs_address_ID;
  logic [REG_W-1:0] rt_address_ID;
  logic             UsesRs_ID;
  logic             UsesRt_ID;
  logic             RegWrite_ID;
  logic             MemRead_ID;
  logic [REG_W-1:0] RegDst1Result_ID;
  logic             Flush_ID;
  logic             Stall_ID;
  logic             Bubble_EX1;

  modport master (
    output rs_address_ID, rt_address_ID, UsesRs_ID, UsesRt_ID,
           RegWrite_ID, MemRead_ID, RegDst1Result_ID, Flush_ID,
    input  Stall_ID, Bubble_EX1
  );

  modport slave (
    input  rs_address_ID, rt_address_ID, UsesRs_ID, UsesRt_ID,
           RegWrite_ID, MemRead_ID, RegDst1Result_ID, Flush_ID,
    output Stall_ID, Bubble_EX1
  );

endinterface

// File: rtl/load_use_scoreboard_match.sv
// Finds the youngest in-flight producer of one source register and flags a hazard
// when that producer's result cannot be forwarded yet.
module scoreboard_match
  import load_use_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic [REG_W-1:0]  src,
  input  logic              use_src,
  output logic              hazard
);

  logic found;

  // Lowest index is youngest; later (older) matches are shadowed by it.
  always_comb begin
    hazard = 1'b0;
    found  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && use_src && (src != ZERO_REG) &&
          slots[i].valid && (slots[i].dest == src)) begin
        found  = 1'b1;
        hazard = (slots[i].cnt != '0);
      end
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use scoreboard: tracks EX1..MEM destinations with forwarding countdowns,
// stalls IF/ID and bubbles EX1 when an ID source is not yet forwardable.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ALU_LAT  = load_use_scoreboard_pkg::ALU_LAT,
  parameter int unsigned LOAD_LAT = load_use_scoreboard_pkg::LOAD_LAT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  load_use_scoreboard_if.slave  id_if,
  output logic [CNT_W-1:0]      stall_count
);

  slot_t [DEPTH-1:0] slots;
  logic              haz_rs;
  logic              haz_rt;
  logic              stall;
  logic              bubble;

  scoreboard_match #(.DEPTH(DEPTH)) u_match_rs (
    .slots   (slots),
    .src     (id_if.rs_address_ID),
    .use_src (id_if.UsesRs_ID),
    .hazard  (haz_rs)
  );

  scoreboard_match #(.DEPTH(DEPTH)) u_match_rt (
    .slots   (slots),
    .src     (id_if.rt_address_ID),
    .use_src (id_if.UsesRt_ID),
    .hazard  (haz_rt)
  );

  // Reset gating keeps both outputs low while Rst_n is asserted, even with Flush_ID high.
  always_comb begin
    stall  = Rst_n && (haz_rs || haz_rt) && !id_if.Flush_ID;
    bubble = Rst_n && (stall || id_if.Flush_ID);
  end

  assign id_if.Stall_ID   = stall;
  assign id_if.Bubble_EX1 = bubble;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      slots <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        slots[i].valid <= slots[i-1].valid;
        slots[i].dest  <= slots[i-1].dest;
        slots[i].cnt   <= cnt_dec(slots[i-1].cnt);
      end
      if (bubble) begin
        slots[0] <= '0;
      end else begin
        slots[0].valid <= id_if.RegWrite_ID;
        slots[0].dest  <= id_if.RegDst1Result_ID;
        slots[0].cnt   <= id_if.MemRead_ID ? CNT_BITS'(LOAD_LAT) : CNT_BITS'(ALU_LAT);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard with an age-based reference model checked every cycle.
module tb_load_use_scoreboard;

  logic Clk;
  logic Rst_n;
  logic [15:0] sc16;
  logic [3:0]  sc4;

  int checks = 0;
  int errors = 0;

  load_use_scoreboard_if ifa ();
  load_use_scoreboard_if ifb ();

  assign ifb.rs_address_ID    = ifa.rs_address_ID;
  assign ifb.rt_address_ID    = ifa.rt_address_ID;
  assign ifb.UsesRs_ID        = ifa.UsesRs_ID;
  assign ifb.UsesRt_ID        = ifa.UsesRt_ID;
  assign ifb.RegWrite_ID      = ifa.RegWrite_ID;
  assign ifb.MemRead_ID       = ifa.MemRead_ID;
  assign ifb.RegDst1Result_ID = ifa.RegDst1Result_ID;
  assign ifb.Flush_ID         = ifa.Flush_ID;

  load_use_scoreboard u_dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .id_if       (ifa),
    .stall_count (sc16)
  );

  load_use_scoreboard #(.CNT_W(4)) u_dut4 (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .id_if       (ifb),
    .stall_count (sc4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a log of what entered EX1 at each edge; a producer issued
  // 'a' edges before the youngest is forwardable once a >= its latency.
  logic       lg_v [4096];
  logic [4:0] lg_d [4096];
  logic       lg_l [4096];
  int cyc    = 0;
  int base   = 0;
  int mcount = 0;

  function automatic logic m_haz(input logic u, input logic [4:0] s);
    if (!u || s == 5'd0) return 1'b0;
    for (int a = 0; a < 4; a++) begin
      int k = cyc - 1 - a;
      if (k < base) return 1'b0;
      if (lg_v[k] && lg_d[k] == s) return a < (lg_l[k] ? 2 : 0);
    end
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    return Rst_n && (m_haz(ifa.UsesRs_ID, ifa.rs_address_ID) ||
                     m_haz(ifa.UsesRt_ID, ifa.rt_address_ID)) && !ifa.Flush_ID;
  endfunction

  function automatic logic m_bubble();
    return Rst_n && (m_stall() || ifa.Flush_ID);
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      base   = cyc;
      mcount = 0;
    end else begin
      logic s, b;
      s = m_stall();
      b = m_bubble();
      lg_v[cyc] = ifa.RegWrite_ID && !b;
      lg_d[cyc] = ifa.RegDst1Result_ID;
      lg_l[cyc] = ifa.MemRead_ID;
      if (s && mcount < 65535) mcount = mcount + 1;
      cyc = cyc + 1;
    end
  end

  always @(negedge Clk) begin
    int e4;
    e4 = (mcount > 15) ? 15 : mcount;
    checks += 5;
    if (ifa.Stall_ID !== m_stall()) begin
      errors++; $display("FAIL stall_id t=%0t got %b expected %b", $time, ifa.Stall_ID, m_stall());
    end
    if (ifa.Bubble_EX1 !== m_bubble()) begin
      errors++; $display("FAIL bubble_ex1 t=%0t got %b expected %b", $time, ifa.Bubble_EX1, m_bubble());
    end
    if (ifb.Stall_ID !== m_stall()) begin
      errors++; $display("FAIL stall_id_w4 t=%0t got %b expected %b", $time, ifb.Stall_ID, m_stall());
    end
    if (sc16 !== 16'(mcount)) begin
      errors++; $display("FAIL stall_count t=%0t got %0d expected %0d", $time, sc16, mcount);
    end
    if (sc4 !== 4'(e4)) begin
      errors++; $display("FAIL stall_count_w4 t=%0t got %0d expected %0d", $time, sc4, e4);
    end
  end

  task automatic drive(input logic ur, input logic [4:0] rs, input logic ut, input logic [4:0] rt,
                       input logic rw, input logic mr, input logic [4:0] rd, input logic fl);
    ifa.UsesRs_ID = ur;  ifa.rs_address_ID = rs;
    ifa.UsesRt_ID = ut;  ifa.rt_address_ID = rt;
    ifa.RegWrite_ID = rw; ifa.MemRead_ID = mr;
    ifa.RegDst1Result_ID = rd; ifa.Flush_ID = fl;
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++; $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Presents one instruction in ID and holds it until it advances; counts stall cycles.
  task automatic step(input string nm, input logic ur, input logic [4:0] rs, input logic ut,
                      input logic [4:0] rt, input logic rw, input logic mr, input logic [4:0] rd,
                      input logic fl, input int exp_st);
    int n = 0;
    bit done = 0;
    drive(ur, rs, ut, rt, rw, mr, rd, fl);
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge Clk);
      if (ifa.Stall_ID) n++; else done = 1;
      @(posedge Clk); #1;
    end
    checks++;
    if (!done || n != exp_st) begin
      errors++; $display("FAIL %s stall_cycles got %0d expected %0d (advanced=%0b)", nm, n, exp_st, done);
    end
  endtask

  task automatic load8();    step("load8", 0, 0, 0, 0, 1, 1, 5'd8, 0, 0); endtask
  task automatic nop();      step("nop",   0, 0, 0, 0, 0, 0, 5'd0, 0, 0); endtask

  initial begin
    Rst_n = 1'b0;
    drive(1, 5'd5, 0, 0, 1, 1, 5'd5, 0);
    repeat (3) @(posedge Clk);
    #1;
    check_val("reset_stall", int'(ifa.Stall_ID), 0);
    check_val("reset_bubble", int'(ifa.Bubble_EX1), 0);
    check_val("reset_count", int'(sc16), 0);
    drive(1, 5'd5, 0, 0, 0, 0, 5'd0, 0);
    @(negedge Clk); #2 Rst_n = 1'b1;
    @(posedge Clk); #1;

    step("post_reset_use5", 1, 5'd5, 0, 0, 0, 0, 5'd0, 0, 0);

    load8();
    step("load_use_rs", 1, 5'd8, 0, 0, 1, 0, 5'd9, 0, 2);
    check_val("count_after_rs", int'(sc16), 2);
    load8();
    step("load_use_rt", 0, 0, 1, 5'd8, 1, 0, 5'd9, 0, 2);
    check_val("count_after_rt", int'(sc16), 4);

    load8(); nop();
    step("load_nop_use", 1, 5'd8, 0, 0, 1, 0, 5'd9, 0, 1);
    load8(); nop(); nop();
    step("load_2nop_use", 1, 5'd8, 0, 0, 1, 0, 5'd9, 0, 0);
    step("alu_w8", 0, 0, 0, 0, 1, 0, 5'd8, 0, 0);
    step("alu_use", 1, 5'd8, 1, 5'd8, 1, 0, 5'd9, 0, 0);
    check_val("count_after_misc", int'(sc16), 5);

    step("load_r0", 0, 0, 0, 0, 1, 1, 5'd0, 0, 0);
    step("use_r0", 1, 5'd0, 1, 5'd0, 1, 0, 5'd9, 0, 0);

    load8();
    step("alu_mask_w8", 0, 0, 0, 0, 1, 0, 5'd8, 0, 0);
    step("masked_use", 1, 5'd8, 0, 0, 1, 0, 5'd9, 0, 0);

    load8();
    drive(1, 5'd8, 0, 0, 1, 0, 5'd9, 1);
    @(negedge Clk);
    check_val("flush_stall", int'(ifa.Stall_ID), 0);
    check_val("flush_bubble", int'(ifa.Bubble_EX1), 1);
    @(posedge Clk); #1;
    check_val("flush_count", int'(sc16), 5);
    step("after_flush_use", 1, 5'd8, 0, 0, 1, 0, 5'd9, 0, 1);
    check_val("count_after_flush", int'(sc16), 6);

    load8();
    drive(1, 5'd8, 0, 0, 0, 0, 5'd0, 0);
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    check_val("mid_stall_high", int'(ifa.Stall_ID), 1);
    #2 Rst_n = 1'b0;
    #1;
    check_val("midrst_stall", int'(ifa.Stall_ID), 0);
    check_val("midrst_bubble", int'(ifa.Bubble_EX1), 0);
    check_val("midrst_count", int'(sc16), 0);
    check_val("midrst_count_w4", int'(sc4), 0);
    @(negedge Clk); #2 Rst_n = 1'b1;
    @(posedge Clk); #1;
    step("post_midrst_use", 1, 5'd8, 0, 0, 0, 0, 5'd0, 0, 0);

    for (int r = 0; r < 9; r++) begin
      load8();
      step("sat_use", 1, 5'd8, 0, 0, 1, 0, 5'd9, 0, 2);
    end
    check_val("sat_count16", int'(sc16), 18);
    check_val("sat_count4", int'(sc4), 15);

    nop(); nop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
